// File: rtl/csr_ctrl_pkg.sv
// Shared definitions for the CSR sequencer: data width, FSM encoding, func3 codes.
package csr_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } csr_state_t;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // True for the six func3 encodings that name a CSR read-modify-write.
  function automatic logic csr_func3_ok(input logic [2:0] f3);
    return (f3 == CSRRW)  || (f3 == CSRRS)  || (f3 == CSRRC) ||
           (f3 == CSRRWI) || (f3 == CSRRSI) || (f3 == CSRRCI);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational new-value computation for CSRRW/S/C and their immediate forms.
module csr_alu
  import csr_ctrl_pkg::*;
(
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [4:0]      zimm_i,
  output logic [XLEN-1:0] new_o
);

  logic [XLEN-1:0] src;

  // Select operand, then apply write / set / clear against the old value.
  always_comb begin
    src   = func3_i[2] ? {{(XLEN-5){1'b0}}, zimm_i} : rs1_i;
    new_o = old_i;
    case (func3_i[1:0])
      2'b01:   new_o = src;
      2'b10:   new_o = old_i | src;
      2'b11:   new_o = old_i & ~src;
      default: new_o = old_i;
    endcase
  end

endmodule

// File: rtl/csr_seq_ctrl.sv
// CSR port sequencer: runs EX-stage CSR ops as read/write/release and
// arbitrates the single CSR port against one-cycle trap writes.
module csr_seq_ctrl
  import csr_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            is_csr_ex,
  input  logic [2:0]      func3_ex,
  input  logic [4:0]      zimm_ex,
  input  logic [11:0]     csr_addr_ex,
  input  logic            csr_write_en_ex,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic            flush_ex,
  input  logic            trap_req,
  input  logic [11:0]     trap_addr,
  input  logic [XLEN-1:0] trap_wdata,
  output logic            trap_gnt,
  output logic [11:0]     csr_addr,
  output logic            csr_re,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_stall,
  output logic [XLEN-1:0] csr_result,
  output logic            csr_result_valid
);

  csr_state_t      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] new_val;
  logic            op_vld;

  assign op_vld     = is_csr_ex && csr_func3_ok(func3_ex);
  assign csr_result = result_q;

  // Old value comes straight off the port: it is valid in WRITE.
  csr_alu u_alu (
    .func3_i (func3_ex),
    .old_i   (csr_rdata),
    .rs1_i   (rs1_data_ex),
    .zimm_i  (zimm_ex),
    .new_o   (new_val)
  );

  // Strobes and next state; everything is held quiet while reset is low so a
  // reset landing in WRITE never reaches the register file.
  always_comb begin
    state_d          = state_q;
    result_d         = result_q;
    trap_gnt         = 1'b0;
    csr_re           = 1'b0;
    csr_we           = 1'b0;
    csr_addr         = '0;
    csr_wdata        = '0;
    csr_stall        = 1'b0;
    csr_result_valid = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (trap_req) begin
            // Trap owns the port; a waiting CSR op keeps the front end held.
            trap_gnt  = 1'b1;
            csr_we    = 1'b1;
            csr_addr  = trap_addr;
            csr_wdata = trap_wdata;
            csr_stall = op_vld;
          end else if (op_vld && !flush_ex) begin
            csr_re    = 1'b1;
            csr_addr  = csr_addr_ex;
            csr_stall = 1'b1;
            state_d   = WRITE;
          end
        end
        WRITE: begin
          csr_stall = 1'b1;
          csr_addr  = csr_addr_ex;
          if (flush_ex) begin
            state_d = IDLE;
          end else begin
            csr_we    = csr_write_en_ex;
            csr_wdata = new_val;
            result_d  = csr_rdata;
            state_d   = RELEASE;
          end
        end
        RELEASE: begin
          csr_result_valid = 1'b1;
          state_d          = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and captured old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_csr_seq_ctrl.sv
// Bench for csr_seq_ctrl: CSR file model, per-cycle reference model, directed ops.
module tb_csr_seq_ctrl;
  import csr_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            is_csr_ex, csr_write_en_ex, flush_ex, trap_req;
  logic [2:0]      func3_ex;
  logic [4:0]      zimm_ex;
  logic [11:0]     csr_addr_ex, trap_addr;
  logic [XLEN-1:0] rs1_data_ex, trap_wdata;
  logic            trap_gnt, csr_re, csr_we, csr_stall, csr_result_valid;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_rdata, csr_wdata, csr_result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .is_csr_ex(is_csr_ex), .func3_ex(func3_ex),
    .zimm_ex(zimm_ex), .csr_addr_ex(csr_addr_ex), .csr_write_en_ex(csr_write_en_ex),
    .rs1_data_ex(rs1_data_ex), .flush_ex(flush_ex), .trap_req(trap_req),
    .trap_addr(trap_addr), .trap_wdata(trap_wdata), .trap_gnt(trap_gnt),
    .csr_addr(csr_addr), .csr_re(csr_re), .csr_rdata(csr_rdata), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .csr_stall(csr_stall), .csr_result(csr_result),
    .csr_result_valid(csr_result_valid)
  );

  // CSR register file: read data one cycle after csr_re, write on the edge.
  logic [XLEN-1:0] mem [0:4095];
  logic            pre_en = 1'b0;
  logic [11:0]     pre_addr = '0;
  logic [XLEN-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (csr_we) mem[csr_addr] <= csr_wdata;
    if (csr_re) csr_rdata <= mem[csr_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a CSR instruction, from the ISA definition.
  function automatic logic [31:0] csr_new(input logic [2:0] f3, input logic [31:0] old,
                                          input logic [31:0] rs1, input logic [4:0] z);
    logic [31:0] s;
    s = f3[2] ? {27'd0, z} : rs1;
    if (f3[1:0] == 2'b01) return s;
    if (f3[1:0] == 2'b10) return old | s;
    return old & ~s;
  endfunction

  // Reference model: how many cycles the current instruction has spent
  // inside its sequence (0 = not started) and the last captured old value.
  int          age = 0;
  logic [31:0] res_m = '0;

  always @(negedge clk) begin
    logic e_gnt, e_re, e_we, e_stall, e_vld, op;
    logic [11:0] e_addr;
    logic [31:0] e_wd;
    int nage;
    e_gnt = 0; e_re = 0; e_we = 0; e_stall = 0; e_vld = 0;
    e_addr = '0; e_wd = '0; nage = age;
    op = is_csr_ex && (func3_ex inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111});
    check("m_result", csr_result, res_m);
    if (!rst_n) begin
      nage = 0;
    end else if (age == 0) begin
      if (trap_req) begin
        e_gnt = 1; e_we = 1; e_addr = trap_addr; e_wd = trap_wdata; e_stall = op;
      end else if (op && !flush_ex) begin
        e_re = 1; e_addr = csr_addr_ex; e_stall = 1; nage = 1;
      end
    end else if (age == 1) begin
      e_stall = 1; e_addr = csr_addr_ex;
      e_we = csr_write_en_ex && !flush_ex;
      if (e_we) e_wd = csr_new(func3_ex, csr_rdata, rs1_data_ex, zimm_ex);
      nage = flush_ex ? 0 : 2;
    end else begin
      e_vld = 1; nage = 0;
    end
    check("m_gnt", {31'd0, trap_gnt}, {31'd0, e_gnt});
    check("m_re", {31'd0, csr_re}, {31'd0, e_re});
    check("m_we", {31'd0, csr_we}, {31'd0, e_we});
    check("m_stall", {31'd0, csr_stall}, {31'd0, e_stall});
    check("m_valid", {31'd0, csr_result_valid}, {31'd0, e_vld});
    if (e_re || e_we || (rst_n && age == 0)) check("m_addr", {20'd0, csr_addr}, {20'd0, e_addr});
    if (e_we || (rst_n && age == 0)) check("m_wdata", csr_wdata, e_wd);
    if (!rst_n) res_m = '0;
    else if (age == 1 && !flush_ex) res_m = csr_rdata;
    age = nage;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_en = 1; pre_addr = a; pre_data = d;
    step();
    pre_en = 0;
  endtask

  task automatic set_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                        input logic [4:0] z, input logic wen);
    is_csr_ex = 1; func3_ex = f3; csr_addr_ex = a; rs1_data_ex = rs1;
    zimm_ex = z; csr_write_en_ex = wen;
  endtask

  // Full three-cycle op with literal per-cycle expectations.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [11:0] a,
                        input logic [31:0] rs1, input logic [4:0] z, input logic wen,
                        input logic [31:0] exp_wd, input logic [31:0] exp_res);
    set_op(f3, a, rs1, z, wen);
    #1;
    check({nm, "_c0_re"}, {31'd0, csr_re}, 32'd1);
    check({nm, "_c0_stall"}, {31'd0, csr_stall}, 32'd1);
    step();
    check({nm, "_c1_we"}, {31'd0, csr_we}, {31'd0, wen});
    if (wen) check({nm, "_c1_wdata"}, csr_wdata, exp_wd);
    check({nm, "_c1_stall"}, {31'd0, csr_stall}, 32'd1);
    step();
    check({nm, "_c2_valid"}, {31'd0, csr_result_valid}, 32'd1);
    check({nm, "_c2_stall"}, {31'd0, csr_stall}, 32'd0);
    check({nm, "_c2_result"}, csr_result, exp_res);
    step();
    is_csr_ex = 0;
  endtask

  initial begin
    rst_n = 0; is_csr_ex = 0; func3_ex = 0; zimm_ex = 0; csr_addr_ex = 0;
    csr_write_en_ex = 0; rs1_data_ex = 0; flush_ex = 0; trap_req = 0;
    trap_addr = 0; trap_wdata = 0; csr_rdata = 0;
    // Pin the reference function with hand-computed values.
    check("fn_rw", csr_new(3'b001, 32'h1234, 32'hDEADBEEF, 5'd0), 32'hDEADBEEF);
    check("fn_rsi", csr_new(3'b110, 32'hF0F0, 32'h0, 5'h05), 32'hF0F5);
    check("fn_rc", csr_new(3'b011, 32'hF0F0, 32'hF, 5'd0), 32'hF0F0);
    check("fn_rci", csr_new(3'b111, 32'hFF, 32'h0, 5'h1F), 32'hE0);
    step(2);
    rst_n = 1;
    step();
    check("rst_result", csr_result, 32'd0);
    check("rst_stall", {31'd0, csr_stall}, 32'd0);
    check("rst_addr", {20'd0, csr_addr}, 32'd0);

    preload(12'h300, 32'h1234);
    preload(12'h340, 32'hF0F0);
    preload(12'h341, 32'hF0F0);
    preload(12'h342, 32'hABCD);
    preload(12'h310, 32'h5);

    run_op("rw", 3'b001, 12'h300, 32'hDEADBEEF, 5'd0, 1'b1, 32'hDEADBEEF, 32'h1234);
    check("rw_mem", mem[12'h300], 32'hDEADBEEF);
    run_op("rsi", 3'b110, 12'h340, 32'h0, 5'h05, 1'b1, 32'hF0F5, 32'hF0F0);
    run_op("rc", 3'b011, 12'h341, 32'hF, 5'd0, 1'b1, 32'hF0F0, 32'hF0F0);
    run_op("rs_nowe", 3'b010, 12'h342, 32'hFF, 5'd0, 1'b0, 32'h0, 32'hABCD);
    check("rs_nowe_mem", mem[12'h342], 32'hABCD);

    // Trap and CSR op arrive together: trap first, op one cycle later.
    trap_req = 1; trap_addr = 12'h341; trap_wdata = 32'h8000_000B;
    set_op(3'b001, 12'h305, 32'h100, 5'd0, 1'b1);
    #1;
    check("tr_c0_gnt", {31'd0, trap_gnt}, 32'd1);
    check("tr_c0_stall", {31'd0, csr_stall}, 32'd1);
    check("tr_c0_re", {31'd0, csr_re}, 32'd0);
    step();
    trap_req = 0;
    #1;
    check("tr_c1_re", {31'd0, csr_re}, 32'd1);
    step();
    check("tr_c2_we", {31'd0, csr_we}, 32'd1);
    check("tr_mem", mem[12'h341], 32'h8000_000B);
    step(2);
    is_csr_ex = 0;

    // Trap raised during WRITE waits for the next IDLE cycle.
    set_op(3'b001, 12'h300, 32'h77, 5'd0, 1'b1);
    step();
    trap_req = 1; trap_addr = 12'h342; trap_wdata = 32'h55;
    #1;
    check("tw_write_gnt", {31'd0, trap_gnt}, 32'd0);
    step();
    check("tw_rel_gnt", {31'd0, trap_gnt}, 32'd0);
    step();
    is_csr_ex = 0;
    #1;
    check("tw_idle_gnt", {31'd0, trap_gnt}, 32'd1);
    step();
    trap_req = 0;
    check("tw_mem", mem[12'h342], 32'h55);

    // Flush in WRITE: no write, no result.
    set_op(3'b001, 12'h340, 32'h9999, 5'd0, 1'b1);
    step();
    flush_ex = 1;
    #1;
    check("fl_we", {31'd0, csr_we}, 32'd0);
    step();
    flush_ex = 0; is_csr_ex = 0;
    #1;
    check("fl_valid", {31'd0, csr_result_valid}, 32'd0);
    check("fl_mem", mem[12'h340], 32'hF0F5);
    step();

    // Reset in WRITE.
    set_op(3'b001, 12'h341, 32'h4444, 5'd0, 1'b1);
    step();
    rst_n = 0;
    #1;
    check("rw_rst_we", {31'd0, csr_we}, 32'd0);
    step();
    rst_n = 1; is_csr_ex = 0;
    #1;
    check("rw_rst_result", csr_result, 32'd0);
    check("rw_rst_stall", {31'd0, csr_stall}, 32'd0);
    check("rw_rst_mem", mem[12'h341], 32'h8000_000B);
    step();

    // Invalid func3 is ignored.
    set_op(3'b000, 12'h300, 32'h1, 5'd0, 1'b1);
    #1;
    check("f0_stall", {31'd0, csr_stall}, 32'd0);
    check("f0_re", {31'd0, csr_re}, 32'd0);
    step(2);
    is_csr_ex = 0;

    // Back-to-back CSRRW to the same address.
    set_op(3'b001, 12'h310, 32'h11, 5'd0, 1'b1);
    step(3);
    rs1_data_ex = 32'h22;
    #1;
    check("bb_c3_re", {31'd0, csr_re}, 32'd1);
    step(2);
    check("bb_result", csr_result, 32'h11);
    step();
    is_csr_ex = 0;
    step(2);
    check("bb_mem", mem[12'h310], 32'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
